// File: rtl/ram_w_ctrl_pkg.sv
// Shared definitions for the burst RAM controller: default geometry,
// FSM state encoding and burst-direction constants.
`ifndef ADDR_SIZE
`define ADDR_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef MEM_LENGTH
`define MEM_LENGTH 16
`endif

package ram_w_ctrl_pkg;

    localparam int CFG_ADDR_W = `ADDR_SIZE;
    localparam int CFG_DATA_W = `DATA_WIDTH;
    localparam int CFG_DEPTH  = `MEM_LENGTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/ram_w_ctrl_if.sv
// Command / write-stream / read-stream bundle between a burst requester
// (master) and the RAM burst controller (slave).
interface ram_w_ctrl_if #(
    parameter int ADDR_W = `ADDR_SIZE,
    parameter int DATA_W = `DATA_WIDTH
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              done;
    logic              busy;

    modport master (
        output cmd_valid, cmd_wr, cmd_base, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_base, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy
    );
endinterface

// File: rtl/ram_w_ctrl_addr_gen.sv
// Burst address generator: loads a start address and word count, then on
// each step advances the address modulo DEPTH and counts beats. 'last' is
// high while the current beat is the final one of the burst.
module ram_w_ctrl_addr_gen #(
    parameter int ADDR_W = `ADDR_SIZE,
    parameter int DEPTH  = `MEM_LENGTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Beat counter is one bit wider than the address so a burst of
    // 2**ADDR_W words (or more, with wrapping) still compares cleanly.
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] len_q;

    // Address / beat counter: load on command accept, advance on each beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            count <= '0;
            len_q <= '0;
        end else if (load) begin
            addr  <= base;
            count <= '0;
            len_q <= len;
        end else if (step) begin
            addr  <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
            count <= count + (ADDR_W + 1)'(1);
        end
    end

    assign last = ((count + (ADDR_W + 1)'(1)) == len_q);

endmodule

// File: rtl/ram_w_ctrl.sv
// Burst controller for a single-port RAM with a one-cycle registered read.
// Accepts write or read burst commands, streams write data straight into
// the RAM, issues back-to-back reads and returns read data one cycle later.
// The RAM itself lives outside; the ram_* ports connect to it.
module ram_w_ctrl
    import ram_w_ctrl_pkg::*;
#(
    parameter int ADDR_W = `ADDR_SIZE,
    parameter int DATA_W = `DATA_WIDTH,
    parameter int DEPTH  = `MEM_LENGTH
) (
    input  logic              clk,
    input  logic              rst,
    ram_w_ctrl_if.slave       bus,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta
);

    state_t            state;
    state_t            state_nx;
    logic              load;
    logic              step;
    logic              last;
    logic              done_set;
    logic              issue_rd;
    logic              ready;
    logic              wready;
    logic              done_p1;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr;

    ram_w_ctrl_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .base (bus.cmd_base),
        .len  (bus.cmd_len),
        .addr (addr),
        .last (last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Write-burst completion pulse and read-data valid, both one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            done_p1 <= done_set;
            vld_p1  <= issue_rd;
        end
    end

    // Next-state logic and per-cycle RAM strobes.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        done_set = 1'b0;
        issue_rd = 1'b0;
        ready    = 1'b0;
        wready   = 1'b0;
        ram_ena  = 1'b0;
        ram_wea  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Holding off while done is pulsing keeps bursts strictly
                // sequential: a new command lands the cycle after done.
                ready = ~done_p1 & ~rst;
                if (bus.cmd_valid && ready) begin
                    if (bus.cmd_len == '0) begin
                        done_set = 1'b1;
                    end else begin
                        load     = 1'b1;
                        state_nx = (bus.cmd_wr == DIR_WRITE) ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                wready = 1'b1;
                if (bus.wr_valid) begin
                    ram_ena = 1'b1;
                    ram_wea = 1'b1;
                    step    = 1'b1;
                    if (last) begin
                        done_set = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                ram_ena  = 1'b1;
                issue_rd = 1'b1;
                step     = 1'b1;
                if (last) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign ram_addra     = ram_ena ? addr : '0;
    assign ram_dina      = ram_wea ? bus.wr_data : '0;

    assign bus.cmd_ready = ready;
    assign bus.wr_ready  = wready;
    assign bus.rd_valid  = vld_p1;
    assign bus.rd_data   = vld_p1 ? ram_douta : '0;
    assign bus.rd_last   = (state == ST_DRAIN);
    assign bus.done      = done_p1 | (state == ST_DRAIN);
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_w_ctrl.sv
// Bench for ram_w_ctrl with DEPTH=16: a behavioural single-port RAM with
// registered read, directed bursts, and a scoreboard monitor.
module tb_ram_w_ctrl;

    logic       clk;
    logic       rst;
    logic       ram_ena;
    logic       ram_wea;
    logic [3:0] ram_addra;
    logic [7:0] ram_dina;
    logic [7:0] ram_douta;
    logic [7:0] ram_mem [16];
    logic [7:0] exp_mem [16];

    logic [11:0] wq  [$];
    logic [3:0]  raq [$];
    logic [8:0]  dq  [$];

    int n_tests;
    int n_fail;
    int done_cnt;

    ram_w_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_w_ctrl #(
        .ADDR_W (4),
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) ram_mem[ram_addra] <= ram_dina;
            else         ram_douta <= ram_mem[ram_addra];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_ena && ram_wea) begin
                if (wq.size() == 0) check("unexpected_write", ram_ena, 1'b0);
                else check("write_addr_data", {ram_addra, ram_dina}, wq.pop_front());
            end
            if (ram_ena && !ram_wea) begin
                if (raq.size() == 0) check("unexpected_read", ram_ena, 1'b0);
                else check("read_addr", ram_addra, raq.pop_front());
            end
            if (bus.rd_valid) begin
                if (dq.size() == 0) check("unexpected_rd_valid", bus.rd_valid, 1'b0);
                else check("rd_last_data", {bus.rd_last, bus.rd_data}, dq.pop_front());
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic issue_cmd(input logic wr, input logic [3:0] base, input logic [4:0] len);
        int guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] base, input logic [4:0] len,
                            input logic [7:0] d0, input logic [7:0] pat);
        int beats = 0;
        int k = 0;
        int d0c = done_cnt;
        for (int i = 0; i < int'(len); i++) begin
            logic [3:0] a;
            a = base + i[3:0];
            wq.push_back({a, d0 + i[7:0]});
            exp_mem[a] = d0 + i[7:0];
        end
        issue_cmd(1'b1, base, len);
        while (beats < int'(len) && k < 40) begin
            bus.wr_valid = (k < 8) ? pat[k] : 1'b1;
            bus.wr_data  = d0 + beats[7:0];
            @(negedge clk);
            check("wr_ready", bus.wr_ready, 1'b1);
            check("wr_ena_follows_valid", ram_ena, bus.wr_valid);
            @(posedge clk); #1;
            if (bus.wr_valid) beats++;
            k++;
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("wr_done_pulse", bus.done, 1'b1);
        check("wr_done_cmd_ready", bus.cmd_ready, 1'b0);
        check("wr_done_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        check("wr_done_count", done_cnt - d0c, 1);
    endtask

    task automatic read_tail(input int len);
        int d0c = done_cnt;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check("rd_issue", {ram_ena, ram_wea}, 2'b10);
            check("rd_valid_delay", bus.rd_valid, (i > 0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rd_drain_valid", bus.rd_valid, 1'b1);
        check("rd_drain_last", bus.rd_last, 1'b1);
        check("rd_drain_done", bus.done, 1'b1);
        check("rd_drain_no_issue", ram_ena, 1'b0);
        @(posedge clk); #1;
        check("rd_done_count", done_cnt - d0c, 1);
        check("rd_idle_busy", bus.busy, 1'b0);
    endtask

    task automatic do_read(input logic [3:0] base, input logic [4:0] len);
        for (int i = 0; i < int'(len); i++) begin
            logic [3:0] a;
            a = base + i[3:0];
            raq.push_back(a);
            dq.push_back({(i == int'(len) - 1), exp_mem[a]});
        end
        issue_cmd(1'b0, base, len);
        read_tail(int'(len));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0c;
        n_tests       = 0;
        n_fail        = 0;
        done_cnt      = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_outputs", {bus.busy, bus.done, bus.rd_valid, bus.wr_ready, ram_ena, ram_wea}, 6'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Write then read base=3 len=4 with data 0xA..0xD
        do_write(4'd3, 5'd4, 8'h0A, 8'hFF);
        do_read(4'd3, 5'd4);

        // Wrap: 14,15,0,1
        do_write(4'd14, 5'd4, 8'h31, 8'hFF);
        do_read(4'd14, 5'd4);

        // Bubbles: wr_valid 1,0,1,1 for three beats
        do_write(4'd7, 5'd3, 8'h70, 8'b0000_1101);
        do_read(4'd7, 5'd3);

        // Zero-length command
        d0c = done_cnt;
        issue_cmd(1'b1, 4'd5, 5'd0);
        @(negedge clk);
        check("zero_len_done", bus.done, 1'b1);
        check("zero_len_busy", bus.busy, 1'b0);
        check("zero_len_cmd_ready", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("zero_len_done_count", done_cnt - d0c, 1);
        @(negedge clk);
        check("zero_len_done_drop", bus.done, 1'b0);
        check("zero_len_ready_back", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Reset during cycle 2 of a len=8 read
        d0c = done_cnt;
        raq.push_back(4'd0);
        issue_cmd(1'b0, 4'd0, 5'd8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rd_valid", bus.rd_valid, 1'b0);
        check("rst_mid_done", bus.done, 1'b0);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_ena", ram_ena, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", bus.cmd_ready, 1'b1);
        check("rst_mid_no_done", done_cnt - d0c, 0);
        @(posedge clk); #1;
        do_read(4'd3, 5'd4);

        // Back-to-back: second command held until the cycle after done
        wq.push_back({4'd10, 8'h55});
        wq.push_back({4'd11, 8'h56});
        exp_mem[10] = 8'h55;
        exp_mem[11] = 8'h56;
        raq.push_back(4'd10);
        raq.push_back(4'd11);
        dq.push_back({1'b0, 8'h55});
        dq.push_back({1'b1, 8'h56});
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b1;
        bus.cmd_base  = 4'd10;
        bus.cmd_len   = 5'd2;
        @(negedge clk);
        check("b2b_first_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_wr   = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h55;
        @(negedge clk);
        check("b2b_ready_in_write", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
        bus.wr_data  = 8'h56;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("b2b_done", bus.done, 1'b1);
        check("b2b_hold_in_done", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_second_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        read_tail(2);

        repeat (2) @(posedge clk);
        #1;
        check("writes_left", wq.size(), 0);
        check("reads_left", raq.size(), 0);
        check("rdata_left", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_w_ctrl.md
RAM_W_CTRL -- requirements
Module: ram_w_ctrl

Interface
REQ-001 Parameter ADDR_W, default `ADDR_SIZE: RAM address width.
REQ-002 Parameter DATA_W, default `DATA_WIDTH: RAM data width.
REQ-003 Parameter DEPTH, default `MEM_LENGTH: number of RAM words; the last valid address is DEPTH-1.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port cmd_valid in 1, cmd_ready out 1: burst command handshake.
REQ-007 Port cmd_wr in 1 (1 = write burst, 0 = read burst); cmd_base in ADDR_W (start address); cmd_len in ADDR_W+1 (word count).
REQ-008 Port wr_valid in 1, wr_ready out 1, wr_data in DATA_W: write-data stream.
REQ-009 Port rd_valid out 1, rd_data out DATA_W, rd_last out 1: read-data stream, with no backpressure.
REQ-010 Port done out 1: one-cycle burst-complete pulse; busy out 1: high in any state other than IDLE.
REQ-011 Port ram_ena out 1, ram_wea out 1, ram_addra out ADDR_W, ram_dina out DATA_W, ram_douta in DATA_W: single-port RAM with 1-cycle registered read.

Function
REQ-012 FSM states: IDLE, WRITE, READ, DRAIN.
REQ-013 IDLE
- cmd_ready=1 in IDLE only.
- On cmd_valid, latch base/len/dir and go to WRITE or READ.
- cmd_len==0: no RAM access; done pulses the next cycle; FSM stays in IDLE.
REQ-014 WRITE
- wr_ready=1.
- Each wr_valid cycle: ram_ena=1, ram_wea=1, ram_addra=cur, ram_dina=wr_data (combinational pass-through).
- cur and beat count advance only on accepted beats; wr_valid low inserts a bubble with ram_ena=0.
REQ-015 WRITE exit: on the accepted last beat, go to IDLE; done pulses the following cycle.
REQ-016 READ
- Issue ram_ena=1, ram_wea=0, ram_addra=cur every cycle for len consecutive cycles, with no bubbles.
- After the final issue, go to DRAIN.
REQ-017 Read data
- rd_valid=1 exactly one cycle after each read issue, with rd_data=ram_douta.
- rd_last and done assert together with the final rd_valid (the DRAIN cycle); then go to IDLE.
REQ-018 Address wrap: cur increments modulo DEPTH (DEPTH-1 -> 0).
REQ-019 cmd_len > DEPTH is legal: addresses keep wrapping and later writes overwrite earlier ones.
REQ-020 Idle RAM controls: ram_ena=0 whenever no access is issued; ram_wea=0 outside WRITE.
REQ-021 Ignored inputs: wr_valid/wr_data are ignored outside WRITE; cmd_valid is ignored outside IDLE.
REQ-022 Ordering: the next command is accepted no earlier than the cycle after done; bursts never overlap.
REQ-023 Counter width: the beat counter is ADDR_W+1 bits, compared against the latched len, with no overflow.

Reset
REQ-024 rst high forces, asynchronously:
- state to IDLE; cur and count to 0;
- all outputs low, except cmd_ready=1 after release.
REQ-025 Reset mid-burst: the burst is aborted with no done pulse and no further RAM access; the next command after release behaves as from power-up.

Structure
REQ-026 Package ram_w_ctrl_pkg holds the FSM state enum and the burst-direction constants; widths come from config.v.
REQ-027 Sub-module ram_w_ctrl_addr_gen: loadable, enable-gated, wrap-at-DEPTH address counter plus beat counter with a last flag.
REQ-028 The controller does not instantiate the RAM; the top level connects the ram_* ports to ram_w.

Verification (DEPTH=16)
REQ-029 Write burst: base=3, len=4, data 0xA..0xD, wr_valid continuous -> addresses 3,4,5,6 written with wea=1; done pulses 1 cycle after the 4th beat.
REQ-030 Read burst: base=3, len=4 after REQ-029 -> ram_ena asserted 4 consecutive cycles; rd_valid 4 cycles, delayed 1, with data 0xA..0xD; rd_last and done on the 4th.
REQ-031 Wrap: write base=14, len=4 -> addresses 14,15,0,1; reading back base=14, len=4 returns the same order.
REQ-032 Bubbles: wr_valid pattern 1,0,1,1 for len=3 -> ram_ena pattern 1,0,1,1; addresses contiguous; exactly one done.
REQ-033 Zero-length command and reset mid-READ:
- cmd_len=0 -> done the next cycle, ram_ena never asserted.
- rst during cycle 2 of a len=8 read -> rd_valid/done drop immediately, state returns to IDLE, no done.
REQ-034 Back-to-back: cmd_valid held high with two queued commands -> the second is accepted only in the cycle after the first done.
